// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] c_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory request/response bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import fetch_pkg::*;

    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemReady;
    logic            imemValid;
    logic [XLEN-1:0] imemRdata;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemValid,
        input  imemRdata
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemValid,
        output imemRdata
    );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry holding slot for a fetched word and its address.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_clear,
    input  wire logic            i_push,
    input  wire logic            i_pop,
    input  wire logic [XLEN-1:0] i_data,
    input  wire logic [XLEN-1:0] i_pc,
    output logic                 o_valid,
    output logic [XLEN-1:0]      o_data,
    output logic [XLEN-1:0]      o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] r_pc;

    // A push wins over a pop so a simultaneous pop+push refills the slot.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_pc   <= '0;
        end else if (i_push) begin
            r_data <= i_data;
            r_pc   <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch with IF/ID register,
//               one-entry skid buffer, redirect and response kill handling.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    fetch_unit_if.master         imem,
    input  wire logic            stall,
    input  wire logic            redirect,
    input  wire logic [XLEN-1:0] redirectPc,
    output logic [XLEN-1:0]      instruction,
    output logic [XLEN-1:0]      pcOut,
    output logic                 instrValid
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            r_kill;
    logic            w_kill_nxt;
    logic            w_kill_rst;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_out;
    logic            r_valid;

    logic            w_req;
    logic            w_issue;
    logic            w_consume;
    logic            w_accept;
    logic            w_out_free;
    logic            w_skid_valid;
    logic [XLEN-1:0] w_skid_data;
    logic [XLEN-1:0] w_skid_pc;
    logic            w_skid_push;
    logic            w_skid_pop;

    assign w_issue    = w_req && imem.imemReady;
    assign w_consume  = r_valid && !stall && !redirect;
    assign w_accept   = (r_state == ST_WAIT) && imem.imemValid && !r_kill && !redirect;
    assign w_out_free = !r_valid || w_consume;
    assign w_skid_pop  = w_consume && w_skid_valid;
    assign w_skid_push = w_accept && (!w_out_free || w_skid_valid);

    // A request abandoned by reset must have its late response swallowed.
    assign w_kill_rst = ((r_state == ST_WAIT) || r_kill) && !imem.imemValid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_REQ;
            r_kill  <= w_kill_rst;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        case (r_state)
            ST_REQ: begin
                if (r_kill && imem.imemValid) begin
                    w_kill_nxt = 1'b0;
                end
                if (w_issue) begin
                    w_state_nxt = ST_WAIT;
                    w_kill_nxt  = redirect;
                end
            end
            ST_WAIT: begin
                if (imem.imemValid) begin
                    w_state_nxt = ST_REQ;
                    w_kill_nxt  = 1'b0;
                end else if (redirect) begin
                    w_kill_nxt = 1'b1;
                end
            end
        endcase
    end

    // Hold off new requests while a stale response is still owed to us.
    always_comb begin
        w_req = (r_state == ST_REQ) && !w_skid_valid && !r_kill && !reset;
    end

    assign imem.imemReq  = w_req;
    assign imem.imemAddr = r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= align_word(RESET_PC);
            r_req_pc <= '0;
        end else begin
            if (redirect) begin
                r_pc <= align_word(redirectPc);
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_instr  <= c_NOP;
            r_pc_out <= '0;
        end else if (redirect) begin
            r_valid <= 1'b0;
        end else if (w_out_free) begin
            if (w_skid_valid) begin
                r_valid  <= 1'b1;
                r_instr  <= w_skid_data;
                r_pc_out <= w_skid_pc;
            end else if (w_accept) begin
                r_valid  <= 1'b1;
                r_instr  <= imem.imemRdata;
                r_pc_out <= r_req_pc;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_clear (redirect),
        .i_push  (w_skid_push),
        .i_pop   (w_skid_pop),
        .i_data  (imem.imemRdata),
        .i_pc    (r_req_pc),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_pc    (w_skid_pc)
    );

    assign instruction = r_instr;
    assign pcOut       = r_pc_out;
    assign instrValid  = r_valid;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imemReq  output  1  request valid to instruction memory.
REQ-005 imemAddr  output  32  word-aligned fetch address; SHALL be valid while imemReq=1.
REQ-006 imemReady  input  1  memory accepts the request this cycle (imemReq && imemReady = issue).
REQ-007 imemValid  input  1  response valid; exactly one response per issued request, in order, 1+ cycles after issue.
REQ-008 imemRdata  input  32  instruction word qualified by imemValid.
REQ-009 stall  input  1  decode cannot accept; output is consumed when instrValid && !stall.
REQ-010 redirect  input  1  branch/jump taken; highest priority event.
REQ-011 redirectPc  input  32  new fetch target; bits[1:0] SHALL be treated as 2'b00.
REQ-012 instruction  output  32  IF/ID instruction register feeding decode/immgen.
REQ-013 pcOut  output  32  address of the word in instruction.
REQ-014 instrValid  output  1  instruction/pcOut hold a live instruction.

Function
REQ-015 State machine SHALL have states REQ (imemReq=1, imemAddr=pc) and WAIT (one request outstanding, imemReq=0).
REQ-016 In REQ, imemReq SHALL be 1 only when the skid entry is empty; on issue: reqPc<=pc, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go WAIT.
REQ-017 In WAIT, on imemValid with kill=0: word goes to the output register if it is empty or consumed this cycle, else into the skid entry; go REQ.
REQ-018 When the output is consumed and the skid entry is full, the skid word SHALL move to the output that same cycle; skid and output order SHALL be preserved.
REQ-019 Latency: a response arriving with an empty output SHALL appear on instrValid the next cycle.
REQ-020 Redirect (any state): pc<=redirectPc; instrValid<=0; skid cleared; the redirect cycle's own output is not consumed.
REQ-021 Redirect in REQ with issue same cycle: that request is killed (kill<=1), go WAIT.
REQ-022 Redirect in REQ without issue: stay REQ; imemAddr=redirectPc from the next cycle.
REQ-023 Redirect in WAIT without imemValid: kill<=1, stay WAIT.
REQ-024 Redirect in WAIT with imemValid same cycle: response discarded, kill<=0, go REQ.
REQ-025 In WAIT with kill=1, imemValid SHALL discard the response, clear kill, go REQ; no output change.
REQ-026 Stall SHALL never drop or duplicate an instruction; at most two words (output + skid) are buffered.

Reset
REQ-027 On reset: state=REQ, pc=RESET_PC, kill=0, skid empty, instrValid=0, instruction=32'h0000_0013 (NOP), pcOut=0, imemReq=0 during the reset cycle.
REQ-028 Reset mid-operation SHALL abandon any outstanding request; a response arriving after reset deasserts SHALL be dropped (kill=1 after reset if a request was outstanding).

Structure
REQ-029 Shared package fetch_pkg SHALL hold the state enum, NOP constant 32'h0000_0013, and XLEN=32.
REQ-030 The one-entry skid buffer SHALL be a sub-module fetch_skid_buf (data+pc+valid).

Verification
REQ-031 Reset, imemReady=1, fixed 1-cycle response latency, stall=0 -> addresses 0,4,8,12 issued; pcOut follows 0,4,8 in order with instrValid high.
REQ-032 stall held 4 cycles with a response landing -> output and skid full, imemReq=0; release -> both words emerge in order, none lost.
REQ-033 redirect to 32'h0000_0100 while in WAIT -> late response discarded; next imemAddr=0x100; first pcOut=0x100.
REQ-034 redirect coincident with imemValid -> response dropped, next issue at redirectPc, kill stays 0.
REQ-035 redirectPc=32'hFFFF_FFFE -> imemAddr 0xFFFF_FFFC, then 0x0000_0000 (wrap).
REQ-036 reset asserted in WAIT, response arrives 2 cycles after release -> response ignored, first pcOut=RESET_PC.
